// File: rtl/serial_word_transmitter.sv
// -----------------------------------------------------------------------------
// serial_word_transmitter
//
// Buffered UART transmitter. Words of WORD_BYTES bytes, each with a per-byte
// valid mask, are queued in a FIFO_DEPTH-entry word FIFO. The transmitter pops
// one word at a time and sends each enabled byte LSB-first as an 8N1/8N2 frame
// (8E1/8E2 when parity is compiled in). Disabled bytes are skipped at a cost
// of one cycle each.
//
// Configuration macro:
//   SERIAL_TX_PARITY_EN  - when defined, an even-parity bit follows the eight
//                          data bits of every frame.
//
// Parameters:
//   FREQ        system clock frequency in Hz
//   RATE        baud rate; BITLENGTH = FREQ/RATE clocks per bit (>= 2)
//   WORD_BYTES  bytes per word (1..8)
//   FIFO_DEPTH  word FIFO depth (power of two, 2..16)
//   STOP_BITS   stop bits per frame (1 or 2)
//
// Ports:
//   clock       in   system clock, rising edge
//   extReset_n  in   asynchronous active-low reset
//   send        in   push strobe, one word per high cycle
//   send_data   in   word, byte k at [8k+7:8k]
//   send_valid  in   per-byte enable
//   tx          out  serial line, idle high (registered)
//   busy        out  FIFO non-empty or transmitter active (registered)
//   full        out  FIFO holds FIFO_DEPTH words (registered)
//   overflow    out  one-cycle pulse after a dropped push (registered)
// -----------------------------------------------------------------------------
module serial_word_transmitter #(
    parameter int FREQ       = 100000000,
    parameter int RATE       = 115200,
    parameter int WORD_BYTES = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int STOP_BITS  = 1
) (
    input  logic                      clock,
    input  logic                      extReset_n,
    input  logic                      send,
    input  logic [8*WORD_BYTES-1:0]   send_data,
    input  logic [WORD_BYTES-1:0]     send_valid,
    output logic                      tx,
    output logic                      busy,
    output logic                      full,
    output logic                      overflow
);

    localparam int BITLENGTH = FREQ / RATE;
    localparam int BCNT_W    = $clog2(BITLENGTH);
    localparam int IDX_W     = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam int CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam int ENT_W     = 9 * WORD_BYTES;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SCAN   = 3'd2,
        S_START  = 3'd3,
        S_DATA   = 3'd4,
`ifdef SERIAL_TX_PARITY_EN
        S_PARITY = 3'd5,
`endif
        S_STOP   = 3'd6
    } state_t;

`ifdef SERIAL_TX_PARITY_EN
    // Even parity of one data byte.
    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction
`endif

    // FIFO storage and bookkeeping
    logic [ENT_W-1:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   push_s, pop_s;

    // Transmit engine
    state_t                 state_q, state_d;
    logic [WORD_BYTES-1:0]  hold_valid_q, hold_valid_d;
    logic [8*WORD_BYTES-1:0] hold_data_q, hold_data_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [7:0]             shift_q, shift_d;
    logic [BCNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [2:0]             bitn_q, bitn_d;
    logic                   stop_n_q, stop_n_d;
`ifdef SERIAL_TX_PARITY_EN
    logic                   parity_q, parity_d;
`endif

    // Registered outputs
    logic                   tx_q, tx_d;
    logic                   busy_q, busy_d;
    logic                   full_q, full_d;
    logic                   overflow_q, overflow_d;

    // Derived conditions
    logic                   bit_end_s;
    logic                   bit_state_s;
    logic                   byte_en_s;
    logic                   idx_last_s;
    logic                   stop_last_s;
    logic                   more_valid_s;

    assign tx       = tx_q;
    assign busy     = busy_q;
    assign full     = full_q;
    assign overflow = overflow_q;

    // Condition decode shared by the FSM and datapath.
    always_comb begin
        push_s      = send & ~full_q;
        pop_s       = (state_q == S_IDLE) && (count_q != {CNT_W{1'b0}});
        bit_end_s   = (bit_cnt_q == BCNT_W'(BITLENGTH - 1));
        byte_en_s   = hold_valid_q[idx_q];
        idx_last_s  = (idx_q == IDX_W'(WORD_BYTES - 1));
        stop_last_s = (stop_n_q == 1'(STOP_BITS - 1));
        // Any enabled byte above the current one decides SCAN vs IDLE after STOP.
        more_valid_s = 1'b0;
        for (int k = 0; k < WORD_BYTES; k++) begin
            more_valid_s = more_valid_s | ((k > int'(idx_q)) & hold_valid_q[k]);
        end
        case (state_q)
            S_START, S_DATA,
`ifdef SERIAL_TX_PARITY_EN
            S_PARITY,
`endif
            S_STOP:  bit_state_s = 1'b1;
            default: bit_state_s = 1'b0;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clock or negedge extReset_n) begin
        if (!extReset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (pop_s) state_d = S_LOAD;
                else       state_d = S_IDLE;
            end
            S_LOAD: state_d = S_SCAN;
            S_SCAN: begin
                if (byte_en_s)       state_d = S_START;
                else if (idx_last_s) state_d = S_IDLE;
                else                 state_d = S_SCAN;
            end
            S_START: begin
                if (bit_end_s) state_d = S_DATA;
                else           state_d = S_START;
            end
            S_DATA: begin
                if (bit_end_s && (bitn_q == 3'd7)) begin
`ifdef SERIAL_TX_PARITY_EN
                    state_d = S_PARITY;
`else
                    state_d = S_STOP;
`endif
                end else begin
                    state_d = S_DATA;
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end_s) state_d = S_STOP;
                else           state_d = S_PARITY;
            end
`endif
            S_STOP: begin
                if (bit_end_s && stop_last_s) begin
                    if (more_valid_s) state_d = S_SCAN;
                    else              state_d = S_IDLE;
                end else begin
                    state_d = S_STOP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values: FIFO pointers, holding word, byte index, bit timing.
    always_comb begin
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        idx_d        = idx_q;
        shift_d      = shift_q;
        bit_cnt_d    = {BCNT_W{1'b0}};
        bitn_d       = bitn_q;
        stop_n_d     = stop_n_q;
`ifdef SERIAL_TX_PARITY_EN
        parity_d     = parity_q;
`endif

        if (push_s) wr_ptr_d = wr_ptr_q + 1'b1;
        else        wr_ptr_d = wr_ptr_q;

        if (pop_s) begin
            rd_ptr_d     = rd_ptr_q + 1'b1;
            hold_data_d  = mem_q[rd_ptr_q][8*WORD_BYTES-1:0];
            hold_valid_d = mem_q[rd_ptr_q][ENT_W-1:8*WORD_BYTES];
        end else begin
            rd_ptr_d     = rd_ptr_q;
        end

        // Bit period counter restarts at every bit boundary and idles at zero.
        if (bit_state_s && !bit_end_s) bit_cnt_d = bit_cnt_q + 1'b1;
        else                           bit_cnt_d = {BCNT_W{1'b0}};

        if (state_q != S_DATA)  bitn_d = 3'd0;
        else if (bit_end_s)     bitn_d = bitn_q + 3'd1;
        else                    bitn_d = bitn_q;

        if (state_q != S_STOP)  stop_n_d = 1'b0;
        else if (bit_end_s)     stop_n_d = stop_n_q + 1'b1;
        else                    stop_n_d = stop_n_q;

        case (state_q)
            S_IDLE: idx_d = {IDX_W{1'b0}};
            S_SCAN: begin
                if (byte_en_s) begin
                    shift_d = hold_data_q[8*idx_q +: 8];
`ifdef SERIAL_TX_PARITY_EN
                    parity_d = even_parity(hold_data_q[8*idx_q +: 8]);
`endif
                end else if (!idx_last_s) begin
                    idx_d = idx_q + 1'b1;
                end else begin
                    idx_d = {IDX_W{1'b0}};
                end
            end
            S_DATA: begin
                if (bit_end_s) shift_d = {1'b0, shift_q[7:1]};
                else           shift_d = shift_q;
            end
            S_STOP: begin
                if (bit_end_s && stop_last_s && more_valid_s) idx_d = idx_q + 1'b1;
                else                                           idx_d = idx_q;
            end
            default: idx_d = idx_q;
        endcase
    end

    // FSM output logic: registered outputs follow the next state.
    always_comb begin
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
`ifdef SERIAL_TX_PARITY_EN
            S_PARITY: tx_d = parity_d;
`endif
            default:  tx_d = 1'b1;
        endcase
        busy_d     = (count_d != {CNT_W{1'b0}}) || (state_d != S_IDLE);
        full_d     = (count_d == CNT_W'(FIFO_DEPTH));
        overflow_d = send & full_q;
    end

    // FIFO storage write; contents need no reset.
    always_ff @(posedge clock) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= {send_valid, send_data};
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clock or negedge extReset_n) begin
        if (!extReset_n) begin
            rd_ptr_q     <= {PTR_W{1'b0}};
            wr_ptr_q     <= {PTR_W{1'b0}};
            count_q      <= {CNT_W{1'b0}};
            hold_valid_q <= {WORD_BYTES{1'b0}};
            hold_data_q  <= {(8*WORD_BYTES){1'b0}};
            idx_q        <= {IDX_W{1'b0}};
            shift_q      <= 8'h00;
            bit_cnt_q    <= {BCNT_W{1'b0}};
            bitn_q       <= 3'd0;
            stop_n_q     <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            parity_q     <= 1'b0;
`endif
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            full_q       <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            bitn_q       <= bitn_d;
            stop_n_q     <= stop_n_d;
`ifdef SERIAL_TX_PARITY_EN
            parity_q     <= parity_d;
`endif
            tx_q         <= tx_d;
            busy_q       <= busy_d;
            full_q       <= full_d;
            overflow_q   <= overflow_d;
        end
    end

endmodule

// File: tb/tb_serial_word_transmitter.sv
// -----------------------------------------------------------------------------
// tb_serial_word_transmitter
//
// Two transmitters (one and two stop bits) share the same stimulus. A
// reference model computes, for every cycle, the expected line level and the
// busy/full/overflow flags from the word queue and the frame timeline rules.
// -----------------------------------------------------------------------------
module tb_serial_word_transmitter;

    localparam int BL    = 10;
    localparam int WB    = 4;
    localparam int DEPTH = 4;
`ifdef SERIAL_TX_PARITY_EN
    localparam int PAR   = 1;
`else
    localparam int PAR   = 0;
`endif

    logic        clock = 1'b0;
    logic        rst_n;
    logic        send;
    logic [31:0] send_data;
    logic [3:0]  send_valid;
    logic [1:0]  tx_s, busy_s, full_s, ovf_s;

    always #5 clock = ~clock;

    serial_word_transmitter #(
        .FREQ(100), .RATE(10), .WORD_BYTES(WB), .FIFO_DEPTH(DEPTH), .STOP_BITS(1)
    ) u_dut_sb1 (
        .clock(clock), .extReset_n(rst_n), .send(send), .send_data(send_data),
        .send_valid(send_valid), .tx(tx_s[0]), .busy(busy_s[0]),
        .full(full_s[0]), .overflow(ovf_s[0])
    );

    serial_word_transmitter #(
        .FREQ(100), .RATE(10), .WORD_BYTES(WB), .FIFO_DEPTH(DEPTH), .STOP_BITS(2)
    ) u_dut_sb2 (
        .clock(clock), .extReset_n(rst_n), .send(send), .send_data(send_data),
        .send_valid(send_valid), .tx(tx_s[1]), .busy(busy_s[1]),
        .full(full_s[1]), .overflow(ovf_s[1])
    );

    int     n_checks = 0;
    int     n_fail   = 0;
    longint cyc      = 0;

    // Reference model state, one set per instance.
    logic [35:0] m_mem [2][DEPTH];
    int          m_rd [2];
    int          m_wr [2];
    int          m_cnt [2];
    logic        m_ovf [2];
    logic        m_busy [2];
    logic [35:0] m_word [2];
    longint      m_start [2];
    longint      m_end [2];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    function automatic int sb_of(input int i);
        return (i == 0) ? 1 : 2;
    endfunction

    // Level of a frame f cycles after its start bit begins.
    function automatic logic frame_bit(input logic [7:0] b, input int f);
        int n;
        n = f / BL;
        if (n == 0) return 1'b0;
        if (n <= 8) return b[n-1];
        if (PAR == 1 && n == 9) return ^b;
        return 1'b1;
    endfunction

    // Line level o cycles after the word was popped (o=0 pop, 1 load, 2 first scan).
    function automatic logic tx_at(input logic [35:0] w, input int o, input int sb);
        logic [31:0] dt;
        logic [3:0]  v;
        logic [7:0]  b;
        int          c, frame;
        dt = w[31:0];
        v  = w[35:32];
        frame = (9 + sb + PAR) * BL;
        c = 2;
        if (o < 2) return 1'b1;
        for (int k = 0; k < WB; k++) begin
            if (o == c) return 1'b1;
            if (v[k]) begin
                if (o > c && o <= c + frame) begin
                    b = 8'(dt >> (8 * k));
                    return frame_bit(b, o - c - 1);
                end
                c = c + 1 + frame;
                if ((v >> (k + 1)) == 4'd0) return 1'b1;
            end else begin
                c = c + 1;
            end
        end
        return 1'b1;
    endfunction

    // Cycles from pop until the transmitter is idle again.
    function automatic int end_off(input logic [35:0] w, input int sb);
        logic [3:0] v;
        int         c, frame;
        v = w[35:32];
        frame = (9 + sb + PAR) * BL;
        c = 2;
        for (int k = 0; k < WB; k++) begin
            if (v[k]) begin
                c = c + 1 + frame;
                if ((v >> (k + 1)) == 4'd0) break;
            end else begin
                c = c + 1;
            end
        end
        return c;
    endfunction

    function automatic logic exp_tx(input int i, input longint t);
        if (t >= m_start[i] && t < m_end[i])
            return tx_at(m_word[i], int'(t - m_start[i]), sb_of(i));
        return 1'b1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_rd[i] = 0; m_wr[i] = 0; m_cnt[i] = 0;
            m_ovf[i] = 1'b0; m_busy[i] = 1'b0;
            m_word[i] = 36'd0; m_start[i] = 0; m_end[i] = 0;
        end
    endtask

    // Advance the model over cycle cyc given that cycle's inputs.
    task automatic model_step(input logic s, input logic [31:0] d, input logic [3:0] v);
        logic acc, pop;
        for (int i = 0; i < 2; i++) begin
            acc = s && (m_cnt[i] != DEPTH);
            pop = (cyc >= m_end[i]) && (m_cnt[i] > 0);
            if (pop) begin
                m_word[i]  = m_mem[i][m_rd[i]];
                m_rd[i]    = (m_rd[i] + 1) % DEPTH;
                m_start[i] = cyc;
                m_end[i]   = cyc + end_off(m_word[i], sb_of(i));
            end
            if (acc) begin
                m_mem[i][m_wr[i]] = {v, d};
                m_wr[i] = (m_wr[i] + 1) % DEPTH;
            end
            m_cnt[i]  = m_cnt[i] + int'(acc) - int'(pop);
            m_ovf[i]  = s && !acc;
            m_busy[i] = (m_cnt[i] != 0) || (cyc + 1 < m_end[i]);
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            check_eq($sformatf("tx_sb%0d", i + 1),       tx_s[i],   exp_tx(i, cyc));
            check_eq($sformatf("busy_sb%0d", i + 1),     busy_s[i], m_busy[i]);
            check_eq($sformatf("full_sb%0d", i + 1),     full_s[i], (m_cnt[i] == DEPTH));
            check_eq($sformatf("overflow_sb%0d", i + 1), ovf_s[i],  m_ovf[i]);
        end
    endtask

    // One clock cycle: apply inputs, step the model, check the next cycle.
    task automatic tick(input logic s, input logic [31:0] d, input logic [3:0] v);
        send = s; send_data = d; send_valid = v;
        model_step(s, d, v);
        @(posedge clock);
        #1;
        cyc++;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(1'b0, 32'd0, 4'd0);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((m_busy[0] || m_busy[1]) && k < 5000) begin
            tick(1'b0, 32'd0, 4'd0);
            k++;
        end
        idle(3);
        check_eq("drain_busy", busy_s, 2'b00);
    endtask

    initial begin
        rst_n = 1'b0; send = 1'b0; send_data = 32'd0; send_valid = 4'd0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        rst_n = 1'b1;
        cyc = 0;
        compare_all();

        // Two enabled bytes, then a word with no enabled bytes.
        tick(1'b1, 32'h0000A55A, 4'b0011);
        drain();
        tick(1'b1, 32'h12345678, 4'b0000);
        drain();

        // Five back-to-back pushes into a four-deep FIFO.
        for (int k = 0; k < 5; k++) tick(1'b1, $urandom, 4'hF);
        drain();

        // All-ones byte, then parity-sensitive bytes 0x07 and 0x03.
        tick(1'b1, 32'h000000FF, 4'b0001);
        drain();
        tick(1'b1, 32'h00000307, 4'b0011);
        drain();

        // Sparse masks with gaps between enabled bytes.
        tick(1'b1, 32'hC33C0FF0, 4'b1010);
        tick(1'b1, 32'h81422418, 4'b1001);
        drain();

        // Random traffic including overflow bursts and empty masks.
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 29) == 0) tick(1'b1, $urandom, 4'($urandom));
            else                            tick(1'b0, 32'd0, 4'd0);
        end
        drain();

        // Reset fifty cycles into a frame, with a word still queued behind it.
        tick(1'b1, 32'h0000005A, 4'b0001);
        tick(1'b1, 32'h000000A5, 4'b0001);
        idle(53);
        rst_n = 1'b0;
        #1;
        check_eq("rst_tx",   tx_s,   2'b11);
        check_eq("rst_busy", busy_s, 2'b00);
        check_eq("rst_full", full_s, 2'b00);
        check_eq("rst_ovf",  ovf_s,  2'b00);
        model_reset();
        @(posedge clock);
        @(posedge clock);
        #1;
        rst_n = 1'b1;
        compare_all();
        idle(60);
        tick(1'b1, 32'h0000003C, 4'b0001);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
